neuro_update_scheduler: RTL
===========================

Name: neuro_update_scheduler

Overview:
- Sequences the shared-rate updates of the neurotransmitter resources (cortisol, dopamine, serotonin, GABA).
- Sits between the per-transmitter regulators and their `resource` counters.
- A programmable prescaler produces update ticks. On each tick a round-robin scan turns the raw regulator requests into one-cycle inc/dec/fast/setval strobes, one resource per cycle.
- A per-resource refractory counter blocks updates after a setval.

Parameters:
- N_RES, 4, number of scheduled resources (2..8); index 0 = cortisol.
- PRESCALE_W, 8, width of the tick period register.
- HOLD_TICKS, 3, ticks a resource stays refractory after a setval (0 disables; max 15).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- enable  in  1  prescaler run enable
- period  in  PRESCALE_W  tick period minus one (0 = tick every cycle)
- req_inc  in  N_RES  regulator increment requests, level-sensitive
- req_dec  in  N_RES  regulator decrement requests
- req_fast  in  N_RES  regulator fast-step qualifiers
- req_set  in  N_RES  regulator setval requests
- inc  out  N_RES  increment strobe to resource[i]
- dec  out  N_RES  decrement strobe to resource[i]
- fast  out  N_RES  fast qualifier, valid only with inc/dec
- setval  out  N_RES  setval strobe to resource[i]
- tick  out  1  one-cycle update tick
- busy  out  1  scan in progress
- overrun  out  1  sticky: a tick fired while busy

Behaviour:
- Reset (asynchronous, rst_n=0) sets the following to 0:
  - all outputs;
  - the prescaler count, ptr and slot;
  - all refractory counters;
  - the state, which is IDLE.
- Reset mid-scan aborts the scan. No strobe is issued after rst_n falls.
- Prescaler:
  - While enable=1 it counts 0..period.
  - When the count equals period, it wraps to 0 and asserts tick (registered) for exactly 1 cycle.
  - While enable=0, the count holds and tick=0. A scan already in progress still completes.
  - A change of period takes effect at the next compare. If count > new period, the counter continues to wrap at the PRESCALE_W maximum.
- FSM states: IDLE, SCAN.
  - IDLE & tick=1: go to SCAN with slot=0 and busy=1 from the next cycle. Every nonzero refractory counter decrements by 1 in this same cycle.
  - SCAN: each cycle samples resource r=(ptr+slot) mod N_RES and registers that resource's strobes; they are visible the next cycle, for 1 cycle.
  - On slot=N_RES-1: return to IDLE and set ptr to (ptr+1) mod N_RES.
  - Latency: tick at cycle T. Resource ptr strobes at T+2. Last resource strobes at T+N_RES+1. busy covers T+1..T+N_RES.
- Tick while busy:
  - The tick is dropped and overrun is set; only reset clears overrun.
  - Refractory counters do not decrement on a dropped tick.
  - tick itself still pulses.
- Per-slot decision for resource r, in priority order:
  1. refr[r]≠0: no strobe.
  2. req_set[r]: setval[r]=1, and refr[r] loads HOLD_TICKS.
  3. req_inc[r] & req_dec[r]: no strobe (cancel).
  4. req_inc[r]: inc[r]=1, fast[r]=req_fast[r].
  5. req_dec[r]: dec[r]=1, fast[r]=req_fast[r].
  6. Otherwise: no strobe.
- Output invariants:
  - At most one resource has any strobe in a given cycle.
  - inc, dec and setval are mutually exclusive.
  - fast=0 whenever inc=dec=0.
- Requests are sampled only in that resource's slot cycle; changes at other times are ignored.
- Refractory counters are 4-bit and saturate at 0. A reload and a decrement never coincide, because reloads happen only in SCAN and decrements only in IDLE.

Test Plan:
1. Reset and prescaler:
   - Stimulus: rst_n pulse, then enable=1, period=9, all requests 0.
   - Required response: tick every 10 cycles. All strobes 0. busy high for 4 cycles after each tick. overrun=0.
2. Round-robin order:
   - Stimulus: period=9, req_inc=4'b1111, req_fast=4'b0010.
   - Required response, first tick: inc strobes for resources 0,1,2,3 on consecutive cycles T+2..T+5, with fast only on resource 1.
   - Required response, second tick: order starts at resource 1 (1,2,3,0).
3. Cancel and priority:
   - Stimulus: req_inc[2]=req_dec[2]=1, req_set[3]=1, req_dec[3]=1.
   - Required response: no strobe for resource 2. setval[3] only, with dec[3]=0.
4. Refractory:
   - Stimulus: HOLD_TICKS=3, req_set[0] held high.
   - Required response: setval[0] on ticks 1, 5, 9. No strobe for resource 0 on ticks 2–4 or 6–8.
5. Overrun:
   - Stimulus: period=1, N_RES=4.
   - Required response: overrun=1 after the first dropped tick and it stays set. Every scan still completes 4 slots.
6. Reset mid-scan:
   - Stimulus: assert rst_n=0 at T+3 of a scan with req_dec=4'b1111.
   - Required response: all outputs 0 immediately. No further strobes. After release, ptr=0 and the first scan starts at resource 0.

Source files
------------

// File: rtl/neuro_update_scheduler.sv
// neuro_update_scheduler: a programmable prescaler produces update ticks. Each accepted
// tick starts a round-robin scan that turns the level-sensitive regulator requests into
// one-cycle inc/dec/fast/setval strobes, one resource per cycle. A per-resource
// refractory counter blocks updates for a number of ticks after a setval.
module neuro_update_scheduler #(
    parameter int unsigned N_RES      = 4,
    parameter int unsigned PRESCALE_W = 8,
    parameter int unsigned HOLD_TICKS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] period,
    input  logic [N_RES-1:0]      req_inc,
    input  logic [N_RES-1:0]      req_dec,
    input  logic [N_RES-1:0]      req_fast,
    input  logic [N_RES-1:0]      req_set,
    output logic [N_RES-1:0]      inc,
    output logic [N_RES-1:0]      dec,
    output logic [N_RES-1:0]      fast,
    output logic [N_RES-1:0]      setval,
    output logic                  tick,
    output logic                  busy,
    output logic                  overrun
);
    localparam int unsigned IW  = (N_RES > 1) ? $clog2(N_RES) : 1;
    localparam int unsigned IW1 = IW + 1;
    localparam logic [IW-1:0] LAST_SLOT = IW'(N_RES - 1);
    localparam logic [IW:0]   N_RES_W   = IW1'(N_RES);
    localparam logic [3:0]    HOLD      = 4'(HOLD_TICKS);

    typedef enum logic {StIdle, StScan} state_t;

    state_t                  state_q, state_d;
    logic [PRESCALE_W-1:0]   cnt_q;
    logic                    tick_q;
    logic [IW-1:0]           ptr_q, ptr_d;
    logic [IW-1:0]           slot_q, slot_d;
    logic [3:0]              refr_q [N_RES];
    logic [3:0]              refr_d [N_RES];
    logic [N_RES-1:0]        blk_q, blk_d;
    logic [N_RES-1:0]        inc_q, inc_d, dec_q, dec_d;
    logic [N_RES-1:0]        fast_q, fast_d, set_q, set_d;
    logic                    ovr_q, ovr_d;
    logic [IW:0]             sum;
    logic [IW:0]             sel_w;
    logic [IW-1:0]           sel;

    // Resource sampled this slot: (ptr + slot) mod N_RES.
    assign sum   = {1'b0, ptr_q} + {1'b0, slot_q};
    assign sel_w = (sum >= N_RES_W) ? sum - N_RES_W : sum;
    assign sel   = sel_w[IW-1:0];

    // Prescaler: count 0..period, registered one-cycle tick on wrap; holds while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else if (enable) begin
            if (cnt_q == period) begin
                cnt_q  <= '0;
                tick_q <= 1'b1;
            end else begin
                cnt_q  <= cnt_q + 1'b1;
                tick_q <= 1'b0;
            end
        end else begin
            tick_q <= 1'b0;
        end
    end

    // Scan state, round-robin pointer, refractory counters and registered strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            slot_q  <= '0;
            refr_q  <= '{default: '0};
            blk_q   <= '0;
            inc_q   <= '0;
            dec_q   <= '0;
            fast_q  <= '0;
            set_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            slot_q  <= slot_d;
            refr_q  <= refr_d;
            blk_q   <= blk_d;
            inc_q   <= inc_d;
            dec_q   <= dec_d;
            fast_q  <= fast_d;
            set_q   <= set_d;
            ovr_q   <= ovr_d;
        end
    end

    // Next-state: accept ticks in IDLE, decide one resource per SCAN cycle.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        slot_d  = slot_q;
        refr_d  = refr_q;
        blk_d   = blk_q;
        inc_d   = '0;
        dec_d   = '0;
        fast_d  = '0;
        set_d   = '0;
        ovr_d   = ovr_q;
        unique case (state_q)
            StIdle: begin
                if (tick_q) begin
                    state_d = StScan;
                    slot_d  = '0;
                    // Blocking uses the count as it stood when the tick arrived, so a
                    // setval suppresses exactly HOLD_TICKS following scans.
                    for (int i = 0; i < N_RES; i++) begin
                        blk_d[i] = (refr_q[i] != 4'd0);
                        if (refr_q[i] != 4'd0) refr_d[i] = refr_q[i] - 4'd1;
                    end
                end
            end
            StScan: begin
                if (tick_q) ovr_d = 1'b1;
                if (!blk_q[sel]) begin
                    if (req_set[sel]) begin
                        set_d[sel]  = 1'b1;
                        refr_d[sel] = HOLD;
                    end else if (!(req_inc[sel] && req_dec[sel])) begin
                        inc_d[sel]  = req_inc[sel];
                        dec_d[sel]  = req_dec[sel];
                        fast_d[sel] = req_fast[sel] & (req_inc[sel] | req_dec[sel]);
                    end
                end
                if (slot_q == LAST_SLOT) begin
                    state_d = StIdle;
                    ptr_d   = (ptr_q == LAST_SLOT) ? '0 : ptr_q + 1'b1;
                end else begin
                    slot_d = slot_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign inc     = inc_q;
    assign dec     = dec_q;
    assign fast    = fast_q;
    assign setval  = set_q;
    assign tick    = tick_q;
    assign busy    = (state_q == StScan);
    assign overrun = ovr_q;

endmodule
